universal_shift_register: RTL
=============================

Name: universal_shift_register

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank.
- Per-cycle mode select: hold, shift-left, shift-right, or parallel load.
- Provides Q and complementary Qbar outputs, plus serial in/out at both ends.
- Tracks shifts since the last load and flags when all loaded bits have been shifted out.
- Used as a serializer/deserializer and a general storage stage in datapath blocks.

Parameters:
- WIDTH, 4, register width in bits; must be >= 2, otherwise elaboration error.
- RESET_VAL, {WIDTH{1'b0}}, value of Q after reset.
- CW, $clog2(WIDTH+1), width of shift_cnt; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; 0 forces hold regardless of mode.
- mode  input  2  operation: 00 HOLD, 01 SHL, 10 SHR, 11 LOAD.
- pin  input  WIDTH  parallel load data.
- sin_lsb  input  1  serial bit entering Q[0] on SHL.
- sin_msb  input  1  serial bit entering Q[WIDTH-1] on SHR.
- rot  input  1  rotate request; honoured only when USR_ROTATE_EN is defined.
- Q  output  WIDTH  register contents.
- Qbar  output  WIDTH  bitwise complement of Q.
- sout_msb  output  1  equals Q[WIDTH-1].
- sout_lsb  output  1  equals Q[0].
- shift_cnt  output  CW  shifts since last load, saturating at WIDTH.
- drained  output  1  high when shift_cnt == WIDTH.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- rst=1 at a rising edge:
  - Q=RESET_VAL, Qbar=~RESET_VAL, shift_cnt=WIDTH, drained=1 (nothing loaded).
  - rst has priority over en and mode.
  - A reset mid-stream discards the data and count immediately.
- en=0, or mode=HOLD: all state holds.
- SHL: Q <= {Q[WIDTH-2:0], sin_lsb}; shift_cnt increments, saturating at WIDTH.
- SHR: Q <= {sin_msb, Q[WIDTH-1:1]}; shift_cnt increments, saturating at WIDTH.
- LOAD: Q <= pin; shift_cnt <= 0; drained falls on the next cycle.
- Latency:
  - Q and shift_cnt update one cycle after the controlling inputs are sampled.
  - Qbar, sout_*, and drained are combinational from registered state, so there is no extra latency.
- Qbar == ~Q at all times, including during reset. There is no state in which Q and Qbar are equal (unlike the gate-level latch).
- Saturation: once shift_cnt == WIDTH, further shifts still move data but the count stays at WIDTH.
- mode is a full 2-bit decode; no illegal encodings.
- No X propagation from unused inputs: pin is ignored except in LOAD; sin_* are ignored except in their shift direction.
- Both serial outputs are valid every cycle, so shifts can be chained back-to-back without bubbles.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined:
  - rot=1 during SHL: Q[WIDTH-1] is fed into Q[0] instead of sin_lsb.
  - rot=1 during SHR: Q[0] is fed into Q[WIDTH-1] instead of sin_msb.
  - Rotates do not increment shift_cnt (data is not consumed).
- Not defined: rot is ignored; behaviour is identical to rot=0.

Decomposition:
- Shared package usr_pkg contains:
  - mode localparams MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11;
  - a function computing CW from WIDTH.
- One natural sub-module, usr_cnt_sat: a CW-bit saturating counter with sync clear, increment, and a flag output.
- Data register and next-state mux stay in the top level.

Test Plan (all with WIDTH=4, RESET_VAL=0):
1. Reset: rst=1 for 1 cycle -> Q=0000, Qbar=1111, shift_cnt=4, drained=1. Then assert rst in the same cycle as LOAD pin=1010 -> Q stays 0000.
2. Load then shift left: LOAD 1011, then 4x SHL with sin_lsb=0.
   - Q sequence: 0110, 1100, 1000, 0000.
   - sout_msb sequence before each shift: 1, 0, 1, 1.
   - shift_cnt 0->4; drained=1 after the 4th shift, and stays 1 on a 5th shift.
3. Shift right fill: from 0000, 4x SHR with sin_msb=1 -> Q=1000, 1100, 1110, 1111. Then en=0 with mode=SHR for 3 cycles -> Q holds 1111 and shift_cnt is unchanged.
4. Mode priority: LOAD 0101 with en=0 -> no change. Then en=1 -> Q=0101 and shift_cnt=0 next cycle. Check Qbar=1010 every cycle.
5. Rotate (USR_ROTATE_EN defined): LOAD 1001, SHL with rot=1 -> Q=0011, shift_cnt=0. Then SHR with rot=1 -> Q=1001. Rebuilt with the macro undefined, the same stimulus gives Q=0010 (sin_lsb=0) and shift_cnt=1.
6. Back-to-back chaining: two instances with A.sout_msb driving B.sin_lsb. After LOAD A=1101, 4x SHL on both -> B=1101 and A.drained=1.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the shift-count width helper.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Bits needed to count 0..width inclusive (the count saturates at width).
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_cnt_sat.sv
// Saturating up-counter with synchronous clear.
// Reset parks the count at MAX, so the flag reads "nothing left".
module usr_cnt_sat #(
  parameter int CW  = 3,
  parameter int MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  // Count register: reset to MAX, clear wins over increment, hold at MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= MAX_V;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flag is decoded from the registered count, no added latency.
  always_comb begin
    sat = (cnt == MAX_V);
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold / shift-left / shift-right /
// parallel load, complementary outputs, serial taps at both ends and a
// count of shifts since the last load.
// Optional build macro: USR_ROTATE_EN enables rotate on SHL/SHR when rot=1;
// rotates recirculate data and therefore leave the shift count alone.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int             CW        = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic             rot,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained
);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("universal_shift_register: WIDTH must be >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             rot_act;
  logic             do_shift;
  logic             do_load;
  logic             cnt_inc;
  logic             fill_lsb;
  logic             fill_msb;

`ifdef USR_ROTATE_EN
  assign rot_act = rot;
`else
  // rot has no effect in this build; tie it off so it is visibly consumed.
  logic rot_unused;
  assign rot_unused = rot;
  assign rot_act    = 1'b0;
`endif

  // Serial fill bits: rotation recirculates the opposite end instead of sin_*.
  always_comb begin
    fill_lsb = rot_act ? q_reg[WIDTH-1] : sin_lsb;
    fill_msb = rot_act ? q_reg[0]       : sin_msb;
  end

  // Next-state mux; en=0 forces hold and unused inputs never reach q_next.
  always_comb begin
    q_next   = q_reg;
    do_shift = 1'b0;
    do_load  = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: q_next = q_reg;
        MODE_SHL: begin
          q_next   = {q_reg[WIDTH-2:0], fill_lsb};
          do_shift = 1'b1;
        end
        MODE_SHR: begin
          q_next   = {fill_msb, q_reg[WIDTH-1:1]};
          do_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_next  = pin;
          do_load = 1'b1;
        end
        default: q_next = q_reg;
      endcase
    end
  end

  // Data register; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= RESET_VAL;
    end else begin
      q_reg <= q_next;
    end
  end

  // Only real shifts consume data; rotations do not advance the count.
  always_comb begin
    cnt_inc = do_shift && !rot_act;
  end

  usr_cnt_sat #(
    .CW  (CW),
    .MAX (WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (do_load),
    .inc (cnt_inc),
    .cnt (shift_cnt),
    .sat (drained)
  );

  // Outputs are pure decodes of the registered data.
  always_comb begin
    Q        = q_reg;
    Qbar     = ~q_reg;
    sout_msb = q_reg[WIDTH-1];
    sout_lsb = q_reg[0];
  end

endmodule
